// File: rtl/odd_seq_if.sv
// Sample/status bundle between an odd-step counter stream and its checker.
// master drives samples and clear; slave returns lock, error and expectation status.
interface odd_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ERR_W = 8
);
    logic [WIDTH-1:0] cnt_i;
    logic             valid_i;
    logic             clr_i;
    logic             locked_o;
    logic             err_o;
    logic [ERR_W-1:0] err_cnt_o;
    logic [WIDTH-1:0] exp_o;

    modport master (
        output cnt_i, valid_i, clr_i,
        input  locked_o, err_o, err_cnt_o, exp_o
    );

    modport slave (
        input  cnt_i, valid_i, clr_i,
        output locked_o, err_o, err_cnt_o, exp_o
    );
endinterface

// File: rtl/odd_seq_checker.sv
// In-line integrity monitor for an odd-step counter stream (1, 3, ... 255, 1, ...).
// Acquires lock after LOCK_CNT consecutive correct samples, flags parity/sequence errors.
module odd_seq_checker #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned UNLOCK_MISS = 2,
    parameter int unsigned ERR_W       = 8
) (
    input logic       clk,
    input logic       rstn,
    odd_seq_if.slave  bus
);
    localparam logic [1:0] StHunt   = 2'd0;
    localparam logic [1:0] StAcq    = 2'd1;
    localparam logic [1:0] StLocked = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [3:0]       match_q, match_d;
    logic [3:0]       miss_q, miss_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] nxt;
    logic             hit;

    assign nxt = bus.cnt_i + WIDTH'(2);
    assign hit = (bus.cnt_i == exp_q);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        if (bus.valid_i) begin
            if (!bus.cnt_i[0]) begin
                err_d   = 1'b1;
                state_d = StHunt;
                exp_d   = '0;
                match_d = '0;
                miss_d  = '0;
            end else begin
                unique case (state_q)
                    StHunt: begin
                        exp_d   = nxt;
                        match_d = 4'd1;
                        state_d = StAcq;
                    end
                    StAcq: begin
                        exp_d = nxt;
                        if (hit) begin
                            match_d = match_q + 4'd1;
                            if (match_q + 4'd1 == 4'(LOCK_CNT)) begin
                                state_d = StLocked;
                                match_d = '0;
                            end
                        end else begin
                            // Any odd value restarts acquisition from this sample.
                            match_d = 4'd1;
                        end
                    end
                    StLocked: begin
                        exp_d = nxt;
                        if (hit) begin
                            miss_d = '0;
                        end else begin
                            err_d = 1'b1;
                            if (miss_q + 4'd1 == 4'(UNLOCK_MISS)) begin
                                state_d = StHunt;
                                exp_d   = '0;
                                match_d = '0;
                                miss_d  = '0;
                            end else begin
                                miss_d = miss_q + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state_d = StHunt;
                        exp_d   = '0;
                        match_d = '0;
                        miss_d  = '0;
                    end
                endcase
            end
        end
    end

    // Clear wins over a same-cycle increment; count saturates at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bus.clr_i) begin
            err_cnt_d = '0;
        end else if (err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StHunt;
            exp_q     <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.locked_o  = (state_q == StLocked);
    assign bus.err_o     = err_q;
    assign bus.err_cnt_o = err_cnt_q;
    assign bus.exp_o     = exp_q;
endmodule

// File: tb/tb_odd_seq_checker.sv
// Scoreboard bench for odd_seq_checker: expected outputs queued per driven sample,
// observed outputs captured on the following falling edge and compared per scenario.
module tb_odd_seq_checker;
    typedef struct packed {
        logic       locked;
        logic       err;
        logic [7:0] err_cnt;
        logic [7:0] exp;
    } out_t;

    logic clk;
    logic rstn;
    int   tests;
    int   failed;
    out_t exp_q[$];
    out_t obs_q[$];

    odd_seq_if #(.WIDTH(8), .ERR_W(8)) bus ();

    odd_seq_checker #(
        .WIDTH(8),
        .LOCK_CNT(4),
        .UNLOCK_MISS(2),
        .ERR_W(8)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t sample_outputs();
        out_t o;
        o.locked  = bus.locked_o;
        o.err     = bus.err_o;
        o.err_cnt = bus.err_cnt_o;
        o.exp     = bus.exp_o;
        return o;
    endfunction

    // Drive one cycle, queue its expected result, capture the DUT's response.
    task automatic drive(input logic v, input logic [7:0] c, input logic clr,
                         input logic l, input logic e, input logic [7:0] ec,
                         input logic [7:0] ex);
        out_t x;
        bus.valid_i = v;
        bus.cnt_i   = c;
        bus.clr_i   = clr;
        x.locked = l; x.err = e; x.err_cnt = ec; x.exp = ex;
        exp_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
        obs_q.push_back(sample_outputs());
        bus.valid_i = 1'b0;
        bus.clr_i   = 1'b0;
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        bus.valid_i = 1'b0;
        bus.clr_i   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        out_t o;
        rstn        = 1'b0;
        bus.valid_i = 1'b1;
        bus.cnt_i   = 8'd6;
        bus.clr_i   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            o = sample_outputs();
            tests++;
            if (o !== 18'd0) begin
                failed++;
                $display("FAIL reset[%0d]: got l=%b e=%b cnt=%0d exp=%0d, want all 0",
                         i, o.locked, o.err, o.err_cnt, o.exp);
            end
        end
        bus.valid_i = 1'b0;
        rstn        = 1'b1;
    endtask

    task automatic test_lock();
        drive(1, 8'd1, 0, 0, 0, 0, 8'd3);
        drive(1, 8'd3, 0, 0, 0, 0, 8'd5);
        drive(1, 8'd5, 0, 0, 0, 0, 8'd7);
        drive(1, 8'd7, 0, 1, 0, 0, 8'd9);
        drive(1, 8'd9, 0, 1, 0, 0, 8'd11);
        drive(1, 8'd11, 0, 1, 0, 0, 8'd13);
        for (int i = 0; exp_q.size() > 0; i++) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL lock[%0d]: got l=%b e=%b cnt=%0d exp=%0d, want l=%b e=%b cnt=%0d exp=%0d",
                         i, o.locked, o.err, o.err_cnt, o.exp, e.locked, e.err, e.err_cnt, e.exp);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1, 8'd245, 0, 0, 0, 0, 8'd247);
        drive(1, 8'd247, 0, 0, 0, 0, 8'd249);
        drive(1, 8'd249, 0, 0, 0, 0, 8'd251);
        drive(1, 8'd251, 0, 1, 0, 0, 8'd253);
        drive(1, 8'd253, 0, 1, 0, 0, 8'd255);
        drive(1, 8'd255, 0, 1, 0, 0, 8'd1);
        drive(1, 8'd1, 0, 1, 0, 0, 8'd3);
        drive(1, 8'd3, 0, 1, 0, 0, 8'd5);
        for (int i = 0; exp_q.size() > 0; i++) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL wrap[%0d]: got l=%b e=%b cnt=%0d exp=%0d, want l=%b e=%b cnt=%0d exp=%0d",
                         i, o.locked, o.err, o.err_cnt, o.exp, e.locked, e.err, e.err_cnt, e.exp);
            end
        end
    endtask

    task automatic test_acq_restart();
        do_reset();
        drive(1, 8'd1, 0, 0, 0, 0, 8'd3);
        drive(1, 8'd3, 0, 0, 0, 0, 8'd5);
        drive(1, 8'd9, 0, 0, 0, 0, 8'd11);
        drive(1, 8'd11, 0, 0, 0, 0, 8'd13);
        drive(1, 8'd13, 0, 0, 0, 0, 8'd15);
        drive(1, 8'd15, 0, 1, 0, 0, 8'd17);
        for (int i = 0; exp_q.size() > 0; i++) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL acq_restart[%0d]: got l=%b e=%b cnt=%0d exp=%0d, want l=%b e=%b cnt=%0d exp=%0d",
                         i, o.locked, o.err, o.err_cnt, o.exp, e.locked, e.err, e.err_cnt, e.exp);
            end
        end
    endtask

    task automatic test_resync();
        do_reset();
        drive(1, 8'd13, 0, 0, 0, 0, 8'd15);
        drive(1, 8'd15, 0, 0, 0, 0, 8'd17);
        drive(1, 8'd17, 0, 0, 0, 0, 8'd19);
        drive(1, 8'd19, 0, 1, 0, 0, 8'd21);
        drive(1, 8'd25, 0, 1, 1, 1, 8'd27);
        drive(1, 8'd27, 0, 1, 0, 1, 8'd29);
        drive(1, 8'd41, 0, 1, 1, 2, 8'd43);
        drive(1, 8'd51, 0, 0, 1, 3, 8'd0);
        // Parity errors from ACQ and from LOCKED, then recovery from HUNT.
        drive(1, 8'd1, 0, 0, 0, 3, 8'd3);
        drive(1, 8'd3, 0, 0, 0, 3, 8'd5);
        drive(1, 8'd6, 0, 0, 1, 4, 8'd0);
        drive(1, 8'd7, 0, 0, 0, 4, 8'd9);
        drive(1, 8'd9, 0, 0, 0, 4, 8'd11);
        drive(1, 8'd11, 0, 0, 0, 4, 8'd13);
        drive(1, 8'd13, 0, 1, 0, 4, 8'd15);
        drive(1, 8'd14, 0, 0, 1, 5, 8'd0);
        drive(1, 8'd7, 0, 0, 0, 5, 8'd9);
        for (int i = 0; exp_q.size() > 0; i++) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL resync_parity[%0d]: got l=%b e=%b cnt=%0d exp=%0d, want l=%b e=%b cnt=%0d exp=%0d",
                         i, o.locked, o.err, o.err_cnt, o.exp, e.locked, e.err, e.err_cnt, e.exp);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 1; k <= 256; k++) begin
            drive(1, 8'((2 * k) % 256), 0, 0, 1, (k > 255) ? 8'd255 : 8'(k), 8'd0);
        end
        drive(1, 8'd4, 1, 0, 1, 0, 8'd0);
        drive(1, 8'd8, 0, 0, 1, 1, 8'd0);
        drive(1, 8'd1, 0, 0, 0, 1, 8'd3);
        drive(0, 8'd2, 1, 0, 0, 0, 8'd3);
        drive(1, 8'd3, 0, 0, 0, 0, 8'd5);
        for (int i = 0; exp_q.size() > 0; i++) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL saturate[%0d]: got l=%b e=%b cnt=%0d exp=%0d, want l=%b e=%b cnt=%0d exp=%0d",
                         i, o.locked, o.err, o.err_cnt, o.exp, e.locked, e.err, e.err_cnt, e.exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1, 8'd1, 0, 0, 0, 0, 8'd3);
        drive(1, 8'd3, 0, 0, 0, 0, 8'd5);
        drive(1, 8'd5, 0, 0, 0, 0, 8'd7);
        drive(1, 8'd7, 0, 1, 0, 0, 8'd9);
        drive(0, 8'd100, 0, 1, 0, 0, 8'd9);
        drive(0, 8'd55, 0, 1, 0, 0, 8'd9);
        drive(0, 8'd0, 0, 1, 0, 0, 8'd9);
        drive(1, 8'd9, 0, 1, 0, 0, 8'd11);
        // Reset wins over a valid sample in the same edge.
        rstn = 1'b0;
        drive(1, 8'd20, 0, 0, 0, 0, 8'd0);
        rstn = 1'b1;
        drive(1, 8'd21, 0, 0, 0, 0, 8'd23);
        drive(1, 8'd23, 0, 0, 0, 0, 8'd25);
        drive(1, 8'd25, 0, 0, 0, 0, 8'd27);
        drive(1, 8'd27, 0, 1, 0, 0, 8'd29);
        for (int i = 0; exp_q.size() > 0; i++) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL gap_midreset[%0d]: got l=%b e=%b cnt=%0d exp=%0d, want l=%b e=%b cnt=%0d exp=%0d",
                         i, o.locked, o.err, o.err_cnt, o.exp, e.locked, e.err, e.err_cnt, e.exp);
            end
        end
    endtask

    initial begin
        tests       = 0;
        failed      = 0;
        rstn        = 1'b0;
        bus.valid_i = 1'b0;
        bus.cnt_i   = '0;
        bus.clr_i   = 1'b0;
        test_reset();
        test_lock();
        test_wrap();
        test_acq_restart();
        test_resync();
        test_saturate();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/odd_seq_checker.md
Name: odd_seq_checker

Overview:
- Receive-side checker for the 8-bit odd counter stream (1, 3, 5, ... 255, 1, ...).
- Samples a counter value, acquires lock on the odd sequence, then tracks it.
- Flags parity and sequence errors and keeps a saturating error count.
- Sits downstream of the odd counter (or any odd-step source) as an in-line integrity monitor.

Parameters:
- WIDTH, 8, data width of the sampled counter value.
- LOCK_CNT, 4, consecutive correct samples needed to declare lock (range 2..15).
- UNLOCK_MISS, 2, consecutive mismatches in LOCKED that drop back to HUNT (range 1..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rstn  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- cnt_i  input  WIDTH  counter value under check.
- valid_i  input  1  cnt_i is a new sample this cycle; cycles with valid_i=0 are ignored entirely.
- clr_i  input  1  synchronous clear of err_cnt_o.
- locked_o  output  1  high while the FSM is in LOCKED.
- err_o  output  1  one-cycle error pulse.
- err_cnt_o  output  ERR_W  saturating count of err_o pulses.
- exp_o  output  WIDTH  next expected value; 0 when not tracking.

Behaviour:
- Reset (rstn=0 at a clk edge): state=HUNT, locked_o=0, err_o=0, err_cnt_o=0, exp_o=0, match/miss counters=0.
- Reset asserted mid-operation aborts any lock in the same edge; no err_o is produced for that cycle's sample.
- All outputs are registered. Latency is 1 cycle: outputs reflect the sample accepted at the previous edge.
- err_o is 0 in every cycle not caused by an error sample.
- Next-value arithmetic: nxt = cnt_i + 2 modulo 2^WIDTH, so 255 -> 1 wraps naturally.
- Parity error: cnt_i[0]=0 on a valid sample in any state.
  - err_o=1 and err_cnt increments.
  - Next state is HUNT, exp_o=0, counters cleared.
- HUNT (odd sample): exp_o<=nxt, match=1, go to ACQ. No error.
- ACQ:
  - cnt_i==exp_o: match+1 and exp_o<=nxt. When match reaches LOCK_CNT, go to LOCKED and set locked_o=1 on that edge.
  - Odd mismatch: restart acquisition. match=1, exp_o<=nxt, stay in ACQ, no err_o.
- LOCKED:
  - cnt_i==exp_o: exp_o<=nxt, miss=0.
  - Odd mismatch: err_o=1, err_cnt increments, miss+1, exp_o<=nxt (resync to the received value).
  - When miss reaches UNLOCK_MISS: go to HUNT, locked_o=0, exp_o=0, counters cleared.
- err_cnt_o saturates at 2^ERR_W-1 and never wraps.
- clr_i=1 sets err_cnt_o=0 and has priority over a same-cycle increment (result 0). err_o still pulses in that case.
- valid_i=0 with clr_i=1 only clears the counter. State and exp_o hold.

Test Plan:
- Reset, then valid samples 1,3,5,7 -> locked_o=1 one cycle after sample 7, exp_o=9, err_cnt_o=0.
- Locked, then samples 253,255,1,3 -> no err_o, exp_o sequence 255,1,3,5, locked_o stays 1 across the wrap.
- Locked at exp 21, sample 25 then 27 -> one err_o pulse, err_cnt_o=1, stays LOCKED, exp_o=29. Next sample 41 then 51 (UNLOCK_MISS=2) -> two more pulses, err_cnt_o=3, locked_o=0, exp_o=0.
- Sample 6 in any state -> err_o=1 for one cycle, state HUNT, exp_o=0. Following 7 -> ACQ with exp_o=9, no error.
- Force err_cnt_o to 255 with repeated even samples, then one more even -> stays 255. Then clr_i=1 together with an even sample -> err_cnt_o=0 and err_o=1.
- Locked stream with valid_i deasserted for 3 cycles, then next odd value -> no error, state held. Assert rstn=0 mid-stream for one cycle -> all outputs 0 on the next cycle, and reacquisition needs LOCK_CNT samples.
